config_chain_loader: RTL and testbench

Serial configuration-chain loader for the FPGA fabric model. It accepts configuration words over a valid/ready stream and serialises them LSB-first onto the head of a chain of configuration flip-flops. It clears the chain before loading and stops after exactly `CHAIN_LEN` bits. It sits directly upstream of the chain's static D flip-flops and drives their data input, shift qualifier and active-low reset.

---
 rtl/ccl_pkg.sv | 20 ++
 rtl/ccl_shifter.sv | 30 +++
 rtl/config_chain_loader.sv | 176 +++++++++++++++++
 tb/tb_config_chain_loader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccl_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states, clear-pulse
// length and counter sizing.
package ccl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT,
        DONE
    } ccl_state_t;

    localparam int CCL_CLR_CYCLES = 1;

    // Bit counter must hold the value CHAIN_LEN itself.
    function automatic int ccl_cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/ccl_shifter.sv
// Parallel-load, right-shift register. serial_out is registered and holds its
// value whenever neither load nor shift is asserted.
module ccl_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  serial_out
);

    // Bits still waiting to reach serial_out; bit 0 is the next one out.
    logic [DATA_WIDTH-1:0] sreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg       <= '0;
            serial_out <= 1'b0;
        end else if (load) begin
            serial_out <= data[0];
            sreg       <= data >> 1;
        end else if (shift) begin
            serial_out <= sreg[0];
            sreg       <= sreg >> 1;
        end
    end

endmodule

// File: rtl/config_chain_loader.sv
// Serialises configuration words LSB-first into a CHAIN_LEN flip-flop chain.
// Optional even-parity checking on input words is enabled by CCL_PARITY_EN.
module config_chain_loader
    import ccl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHAIN_LEN  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
`ifdef CCL_PARITY_EN
    input  logic                  in_parity,
`endif
    output logic                  chain_rst_n,
    output logic                  chain_en,
    output logic                  chain_d,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = ccl_cnt_width(CHAIN_LEN);
    localparam int WB_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CLR_W = (CCL_CLR_CYCLES > 1) ? $clog2(CCL_CLR_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT    = WB_W'(DATA_WIDTH - 1);
    localparam logic [CLR_W-1:0] CLR_LAST     = CLR_W'(CCL_CLR_CYCLES - 1);
    localparam logic             ONE_BIT_WORD = (DATA_WIDTH == 1);

    ccl_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WB_W-1:0]  wbit;
    logic [WB_W-1:0]  wbit_inc;
    logic [CLR_W-1:0] clr_cnt;

    logic accept;
    logic bad_word;
    logic take_word;
    logic shift_bit;
    logic chain_full;
    logic word_end;

    // bit_cnt counts bits already shifted; in SHIFT, cnt_inc includes the one on chain_d now.
    assign cnt_inc    = bit_cnt + 1'b1;
    assign wbit_inc   = wbit + 1'b1;
    assign accept     = in_valid && in_ready;
    assign chain_full = (cnt_inc == FULL_CNT);
    assign word_end   = (wbit == LAST_WBIT);
    assign take_word  = accept && !bad_word;
    assign shift_bit  = (state == SHIFT) && !chain_full && !word_end;

`ifdef CCL_PARITY_EN
    assign bad_word = accept && (^{in_data, in_parity});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (bad_word) begin
            err <= 1'b1;
        end
    end
`else
    assign bad_word = 1'b0;
    assign err      = 1'b0;
`endif

    ccl_shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (take_word),
        .shift     (shift_bit),
        .data      (in_data),
        .serial_out(chain_d)
    );

    // NOTE: all state and outputs here use non-blocking assignments so every
    // branch sees the pre-edge values of state, bit_cnt and wbit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            wbit        <= '0;
            clr_cnt     <= '0;
            in_ready    <= 1'b0;
            chain_rst_n <= 1'b1;
            chain_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CLEAR;
                        chain_rst_n <= 1'b0;
                        busy        <= 1'b1;
                        clr_cnt     <= '0;
                    end
                end

                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state       <= LOAD;
                        chain_rst_n <= 1'b1;
                        in_ready    <= 1'b1;
                        bit_cnt     <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                LOAD: begin
                    if (bad_word) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                    end else if (accept) begin
                        state    <= SHIFT;
                        chain_en <= 1'b1;
                        wbit     <= '0;
                        in_ready <= ONE_BIT_WORD && (bit_cnt < LAST_CNT);
                    end
                end

                SHIFT: begin
                    bit_cnt <= cnt_inc;
                    if (chain_full) begin
                        state    <= DONE;
                        chain_en <= 1'b0;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                    end else if (word_end) begin
                        if (bad_word) begin
                            state    <= DONE;
                            chain_en <= 1'b0;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else if (accept) begin
                            // Next word captured on the last bit of this one: no bubble.
                            wbit     <= '0;
                            in_ready <= ONE_BIT_WORD && (cnt_inc < LAST_CNT);
                        end else begin
                            state    <= LOAD;
                            chain_en <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        wbit     <= wbit_inc;
                        in_ready <= (wbit_inc == LAST_WBIT) && (cnt_inc < LAST_CNT);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: a 64-bit and a 12-bit chain instance,
// checked every cycle against a word-stream model plus literal timing points.
module tb_config_chain_loader;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic sel = 1'b0;
    logic [DW-1:0] in_data = '0;
`ifdef CCL_PARITY_EN
    logic in_parity = 1'b0;
    logic pars[8];
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic a_start, a_valid, a_ready, a_rst_n, a_en, a_d, a_busy, a_done, a_err;
    logic b_start, b_valid, b_ready, b_rst_n, b_en, b_d, b_busy, b_done, b_err;
    logic m_ready, m_rst_n, m_en, m_d, m_busy, m_done, m_err;

    assign a_start = start & ~sel;
    assign a_valid = in_valid & ~sel;
    assign b_start = start & sel;
    assign b_valid = in_valid & sel;

    config_chain_loader #(.DATA_WIDTH(DW), .CHAIN_LEN(64)) dut_64 (
        .clk(clk), .reset(reset), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(in_data),
`ifdef CCL_PARITY_EN
        .in_parity(in_parity),
`endif
        .chain_rst_n(a_rst_n), .chain_en(a_en), .chain_d(a_d), .busy(a_busy),
        .done(a_done), .err(a_err)
    );

    config_chain_loader #(.DATA_WIDTH(DW), .CHAIN_LEN(12)) dut_12 (
        .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(in_data),
`ifdef CCL_PARITY_EN
        .in_parity(in_parity),
`endif
        .chain_rst_n(b_rst_n), .chain_en(b_en), .chain_d(b_d), .busy(b_busy),
        .done(b_done), .err(b_err)
    );

    assign m_ready = sel ? b_ready : a_ready;
    assign m_rst_n = sel ? b_rst_n : a_rst_n;
    assign m_en    = sel ? b_en    : a_en;
    assign m_d     = sel ? b_d     : a_d;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: accepted good words form an LSB-first bit stream; the chain must
    // receive exactly the first min(CHAIN_LEN, 8*good_words) bits of it.
    bit exp_q[$];
    bit stream[$];
    int shifted = 0;
    int good_words = 0;
    bit bad_seen = 0;
    bit hs_bad;
    logic [63:0] chain_img = '0;
    logic [63:0] exp_img;
    logic [63:0] img_mask;
    logic prev_d = 1'b0;
    logic prev_sel = 1'b0;
    bit prev_ok = 0;
    int mon_c;
    int mon_s;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            stream.delete();
            shifted = 0;
            good_words = 0;
            bad_seen = 0;
            chain_img = '0;
            prev_ok = 0;
        end else begin
            mon_c = sel ? 12 : 64;
            if (prev_sel != sel) prev_ok = 0;
            if (start && !m_busy) begin
                exp_q.delete();
                stream.delete();
                shifted = 0;
                good_words = 0;
                bad_seen = 0;
            end
            if (!m_rst_n) chain_img = '0;
            if (m_en) begin
                if (exp_q.size() == 0) check("chain_en_without_data", 1, 0);
                else check("chain_d", m_d, exp_q.pop_front());
                chain_img = {chain_img[62:0], m_d};
                shifted++;
            end else if (prev_ok) begin
                check("chain_d_hold", m_d, prev_d);
            end
            if (!m_busy) check("idle_quiet", {m_en, m_ready, m_done}, 3'b000);
            if (in_valid && m_ready) begin
                hs_bad = 0;
`ifdef CCL_PARITY_EN
                hs_bad = ^{in_data, in_parity};
`endif
                if (hs_bad) begin
                    bad_seen = 1;
                end else begin
                    good_words++;
                    for (int i = 0; i < DW; i++) begin
                        exp_q.push_back(in_data[i]);
                        stream.push_back(in_data[i]);
                    end
                end
            end
            if (m_done) begin
                mon_s = (good_words * DW < mon_c) ? good_words * DW : mon_c;
                exp_img = '0;
                for (int b = 0; b < mon_s; b++) exp_img[mon_s - 1 - b] = stream[b];
                img_mask = (mon_c == 64) ? '1 : ((64'd1 << mon_c) - 64'd1);
                check("done_shift_count", shifted, mon_s);
                check("chain_image", chain_img & img_mask, exp_img);
                check("done_busy", m_busy, 1);
                check("done_err", m_err, bad_seen);
                exp_q.delete();
            end
            prev_d = m_d;
            prev_sel = sel;
            prev_ok = 1;
        end
    end

    logic [DW-1:0] words[8];

    task automatic run_load(input int n, input int stall_idx, input int stall_len,
                            input int restart_at, output int done_cyc, output int en_cnt,
                            output int first_en, output int last_en, output logic [63:0] dseq,
                            output int rst_lows, output int rst_cyc, output int ready_cyc);
        int k;
        int cyc;
        int stall_left;
        bit accepted;
        k = 0;
        stall_left = stall_len;
        done_cyc = -1;
        en_cnt = 0;
        first_en = -1;
        last_en = -1;
        dseq = '0;
        rst_lows = 0;
        rst_cyc = -1;
        ready_cyc = -1;
        start = 1'b1;
        in_valid = 1'b0;
        tick();
        cyc = 1;
        start = 1'b0;
        while (done_cyc < 0 && cyc < 400) begin
            if (!m_rst_n) begin
                rst_lows++;
                if (rst_cyc < 0) rst_cyc = cyc;
            end
            if (m_ready && ready_cyc < 0) ready_cyc = cyc;
            if (m_en) begin
                if (en_cnt < 64) dseq[en_cnt] = m_d;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                en_cnt++;
                if (en_cnt == restart_at) start = 1'b1;
            end
            if (m_done) done_cyc = cyc;
            if (k == stall_idx && stall_left > 0 && m_ready) begin
                in_valid = 1'b0;
                stall_left--;
            end else if (k < n) begin
                in_valid = 1'b1;
                in_data = words[k];
`ifdef CCL_PARITY_EN
                in_parity = pars[k];
`endif
            end else begin
                in_valid = 1'b0;
            end
            accepted = in_valid && m_ready;
            tick();
            cyc++;
            start = 1'b0;
            if (accepted) k++;
        end
        in_valid = 1'b0;
        check("done_seen", done_cyc >= 0, 1);
        tick();
        check("post_done_idle", {m_done, m_busy}, 2'b00);
    endtask

    task automatic set_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input int bad_idx);
        words[0] = w0;
        words[1] = w1;
`ifdef CCL_PARITY_EN
        pars[0] = ^w0;
        pars[1] = ^w1;
        if (bad_idx >= 0 && bad_idx < 2) pars[bad_idx] = ~pars[bad_idx];
`else
        if (bad_idx > 1) words[1] = w1;
`endif
    endtask

    int done_cyc, en_cnt, first_en, last_en, rst_lows, rst_cyc, ready_cyc;
    logic [63:0] dseq;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_vals_64", {a_ready, a_rst_n, a_en, a_d, a_busy, a_done, a_err}, 7'b0100000);
        check("reset_vals_12", {b_ready, b_rst_n, b_en, b_d, b_busy, b_done, b_err}, 7'b0100000);
        reset = 1'b1;
        tick();
        check("idle_after_reset", {a_ready, a_rst_n, a_en, a_busy, a_done}, 5'b01000);

        // 64-bit chain, eight words 0x01..0x08 streamed back to back.
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            words[i] = DW'(i + 1);
`ifdef CCL_PARITY_EN
            pars[i] = ^words[i];
`endif
        end
        run_load(8, -1, 0, -1, done_cyc, en_cnt, first_en, last_en, dseq, rst_lows, rst_cyc, ready_cyc);
        check("c64_clear_cycle", rst_cyc, 1);
        check("c64_clear_len", rst_lows, 1);
        check("c64_ready_cycle", ready_cyc, 2);
        check("c64_first_shift", first_en, 3);
        check("c64_shift_count", en_cnt, 64);
        check("c64_no_bubble", last_en - first_en + 1, 64);
        check("c64_seq_head", dseq[15:0], 16'h0201);
        check("c64_seq_tail", dseq[63:56], 8'h08);
        check("c64_done_cycle", done_cyc, 67);

        // Reset while shifting bit 5 of the first word.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mid_ready", m_ready, 1);
        in_valid = 1'b1;
        in_data = 8'h3C;
`ifdef CCL_PARITY_EN
        in_parity = 1'b0;
`endif
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("mid_bit5", {m_en, m_d}, 2'b11);
        reset = 1'b0;
        #1;
        check("mid_reset_vals", {a_ready, a_rst_n, a_en, a_d, a_busy, a_done, a_err}, 7'b0100000);
        tick();
        reset = 1'b1;
        tick();
        check("mid_idle", {a_ready, a_en, a_busy, a_done}, 4'b0000);
        run_load(8, -1, 0, -1, done_cyc, en_cnt, first_en, last_en, dseq, rst_lows, rst_cyc, ready_cyc);
        check("mid_reload_count", en_cnt, 64);
        check("mid_reload_done", done_cyc, 67);

        // 12-bit chain: 0xFF then 0xA5, upper nibble of 0xA5 dropped.
        sel = 1'b1;
        set_words(8'hFF, 8'hA5, -1);
        run_load(2, -1, 0, -1, done_cyc, en_cnt, first_en, last_en, dseq, rst_lows, rst_cyc, ready_cyc);
        check("c12_shift_count", en_cnt, 12);
        check("c12_seq", dseq[11:0], 12'h5FF);
        check("c12_done_cycle", done_cyc, 15);

        // Three-cycle stall before the second word.
        run_load(2, 1, 3, -1, done_cyc, en_cnt, first_en, last_en, dseq, rst_lows, rst_cyc, ready_cyc);
        check("stall_shift_count", en_cnt, 12);
        check("stall_bubbles", (last_en - first_en + 1) - en_cnt, 3);
        check("stall_done_cycle", done_cyc, 18);
        check("stall_seq", dseq[11:0], 12'h5FF);

        // start pulsed mid-SHIFT must be ignored.
        run_load(2, -1, 0, 4, done_cyc, en_cnt, first_en, last_en, dseq, rst_lows, rst_cyc, ready_cyc);
        check("restart_clear_len", rst_lows, 1);
        check("restart_shift_count", en_cnt, 12);
        check("restart_done_cycle", done_cyc, 15);

`ifdef CCL_PARITY_EN
        // Second word 0x03 with in_parity=1 fails even parity.
        set_words(8'hFF, 8'h03, 1);
        run_load(2, -1, 0, -1, done_cyc, en_cnt, first_en, last_en, dseq, rst_lows, rst_cyc, ready_cyc);
        check("par_shift_count", en_cnt, 8);
        check("par_done_cycle", done_cyc, 11);
        check("par_err_sticky", m_err, 1);
        set_words(8'hFF, 8'hA5, -1);
        run_load(2, -1, 0, -1, done_cyc, en_cnt, first_en, last_en, dseq, rst_lows, rst_cyc, ready_cyc);
        check("par_err_cleared", m_err, 0);
        check("par_recover_count", en_cnt, 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
